// File: rtl/risk_mem_arbiter.sv
// Pre-trade risk gate: arbitrates order and max-config requests onto a single
// client risk memory with read-modify-write of {max, accumulated} words.
module risk_mem_arbiter #(
    parameter int RD_WAIT = 4,
    parameter int WR_WAIT = 6
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ord_valid,
    output logic        ord_ready,
    input  logic [8:0]  ord_client,
    input  logic [15:0] ord_qty,

    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [8:0]  cfg_client,
    input  logic [15:0] cfg_max,

    output logic        resp_valid,
    output logic        resp_accept,
    output logic [8:0]  resp_client,

    output logic [8:0]  mem_rdindex,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    // state | meaning
    // IDLE  | arbitrating, ready raised for the granted requester
    // RD    | memory read latency, index held
    // CHECK | limit check / new word formed
    // WR    | write strobe held WR_WAIT cycles
    // RESP  | one-cycle order verdict
    typedef enum logic [2:0] {IDLE, RD, CHECK, WR, RESP} state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_cfg;
    logic [8:0]       client_q;
    logic [15:0]      operand_q;
    logic [31:0]      rdata_q;
    logic             last_cfg;

    logic [15:0] acc;
    logic [15:0] max_val;
    logic [16:0] sum;
    logic        ord_ok;
    logic        ord_pick;
    logic        cfg_pick;

    assign acc     = rdata_q[15:0];
    assign max_val = rdata_q[31:16];
    assign sum     = {1'b0, acc} + {1'b0, operand_q};
    assign ord_ok  = !sum[16] && (sum[15:0] <= max_val);

    // Round-robin on a tie: whoever was not granted last goes first.
    assign ord_pick = ord_valid && (!cfg_valid || last_cfg);
    assign cfg_pick = cfg_valid && (!ord_valid || !last_cfg);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_cfg      <= 1'b0;
            client_q    <= '0;
            operand_q   <= '0;
            rdata_q     <= '0;
            last_cfg    <= 1'b1;
            ord_ready   <= 1'b0;
            cfg_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_accept <= 1'b0;
            resp_client <= '0;
            mem_rdindex <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ord_valid && ord_ready) begin
                        is_cfg      <= 1'b0;
                        client_q    <= ord_client;
                        operand_q   <= ord_qty;
                        mem_rdindex <= ord_client;
                        last_cfg    <= 1'b0;
                        ord_ready   <= 1'b0;
                        cfg_ready   <= 1'b0;
                        cnt         <= RD_LOAD;
                        state       <= RD;
                    end else if (cfg_valid && cfg_ready) begin
                        is_cfg      <= 1'b1;
                        client_q    <= cfg_client;
                        operand_q   <= cfg_max;
                        mem_rdindex <= cfg_client;
                        last_cfg    <= 1'b1;
                        ord_ready   <= 1'b0;
                        cfg_ready   <= 1'b0;
                        cnt         <= RD_LOAD;
                        state       <= RD;
                    end else begin
                        ord_ready <= ord_pick;
                        cfg_ready <= cfg_pick;
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        rdata_q <= mem_rdata;
                        state   <= CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (is_cfg) begin
                        mem_wdata <= {operand_q, acc};
                        mem_we    <= 1'b1;
                        cnt       <= WR_LOAD;
                        state     <= WR;
                    end else if (ord_ok) begin
                        mem_wdata <= {max_val, sum[15:0]};
                        mem_we    <= 1'b1;
                        cnt       <= WR_LOAD;
                        state     <= WR;
                    end else begin
                        resp_valid  <= 1'b1;
                        resp_accept <= 1'b0;
                        resp_client <= client_q;
                        state       <= RESP;
                    end
                end
                WR: begin
                    if (cnt == '0) begin
                        mem_we <= 1'b0;
                        if (is_cfg) begin
                            state <= IDLE;
                        end else begin
                            resp_valid  <= 1'b1;
                            resp_accept <= 1'b1;
                            resp_client <= client_q;
                            state       <= RESP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risk_mem_arbiter.sv
// Scoreboard bench for risk_mem_arbiter: reference word model, verdict and
// latency checks, round-robin grant order and reset abort.
module tb_risk_mem_arbiter;

    localparam int RD_WAIT = 4;
    localparam int WR_WAIT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ord_valid = 1'b0;
    logic        ord_ready;
    logic [8:0]  ord_client = '0;
    logic [15:0] ord_qty = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [8:0]  cfg_client = '0;
    logic [15:0] cfg_max = '0;
    logic        resp_valid;
    logic        resp_accept;
    logic [8:0]  resp_client;
    logic [8:0]  mem_rdindex;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    risk_mem_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_client(ord_client), .ord_qty(ord_qty),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_client(cfg_client), .cfg_max(cfg_max),
        .resp_valid(resp_valid), .resp_accept(resp_accept), .resp_client(resp_client),
        .mem_rdindex(mem_rdindex), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];

    assign mem_rdata = mem[mem_rdindex];

    int cyc = 0;
    int we_cycles = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_rdindex] <= mem_wdata;
            we_cycles <= we_cycles + 1;
        end
    end

    typedef struct {
        logic [8:0] client;
        logic       accept;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   grant_cyc_q[$];
    int   grant_log[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ord_valid && ord_ready) begin
                grant_log.push_back(0);
                grant_cyc_q.push_back(cyc);
            end
            if (cfg_valid && cfg_ready) grant_log.push_back(1);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    int g;
                    e = exp_q.pop_front();
                    g = (grant_cyc_q.size() != 0) ? grant_cyc_q.pop_front() : 0;
                    check("resp_client", 32'(resp_client), 32'(e.client));
                    check("resp_accept", 32'(resp_accept), 32'(e.accept));
                    check("resp_latency", 32'(cyc - g), 32'(e.lat));
                end
            end
        end else begin
            grant_cyc_q.delete();
        end
    end

    task automatic push_ord(input logic [8:0] c, input logic [15:0] q);
        exp_t e;
        logic [16:0] s;
        s = {1'b0, ref_mem[c][15:0]} + {1'b0, q};
        e.client = c;
        e.accept = !s[16] && (s[15:0] <= ref_mem[c][31:16]);
        e.lat    = e.accept ? RD_WAIT + WR_WAIT + 2 : RD_WAIT + 2;
        if (e.accept) ref_mem[c] = {ref_mem[c][31:16], s[15:0]};
        exp_q.push_back(e);
    endtask

    task automatic push_cfg(input logic [8:0] c, input logic [15:0] m);
        ref_mem[c] = {m, ref_mem[c][15:0]};
    endtask

    task automatic drive_ord(input logic [8:0] c, input logic [15:0] q);
        int n;
        ord_client = c;
        ord_qty    = q;
        ord_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ord_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ord_ready) check("ord_handshake_timeout", 32'(ord_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic [8:0] c, input logic [15:0] m);
        int n;
        cfg_client = c;
        cfg_max    = m;
        cfg_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) check("cfg_handshake_timeout", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        if (exp_q.size() != 0) check("resp_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[5]  = 32'h0000_0010;
        mem[7]  = 32'hFFFF_FFF0;
        mem[9]  = 32'h0000_0000;
        mem[10] = 32'h1000_0000;
        mem[11] = 32'h1000_0000;
        mem[12] = 32'hFFFF_0000;
        mem[20] = 32'h0000_0033;
        mem[21] = 32'h0000_0033;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];

        repeat (3) @(posedge clk);
        #1;
        check("rst_ord_ready",   32'(ord_ready),   32'd0);
        check("rst_cfg_ready",   32'(cfg_ready),   32'd0);
        check("rst_resp_valid",  32'(resp_valid),  32'd0);
        check("rst_mem_we",      32'(mem_we),      32'd0);
        check("rst_mem_wdata",   mem_wdata,        32'd0);
        check("rst_mem_rdindex", 32'(mem_rdindex), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        push_cfg(5, 16'h0100);
        drive_cfg(5, 16'h0100);
        cfg_valid = 1'b0;
        wait_idle();
        check("cfg_word", mem[5], 32'h0100_0010);

        w0 = we_cycles;
        push_ord(5, 16'h00F0);
        drive_ord(5, 16'h00F0);
        ord_valid = 1'b0;
        wait_idle();
        check("accept_word", mem[5], 32'h0100_0100);
        check("accept_we_cycles", 32'(we_cycles - w0), 32'(WR_WAIT));

        w0 = we_cycles;
        push_ord(5, 16'h0001);
        drive_ord(5, 16'h0001);
        ord_valid = 1'b0;
        wait_idle();
        check("overlimit_word", mem[5], 32'h0100_0100);
        check("overlimit_no_we", 32'(we_cycles - w0), 32'd0);

        push_ord(7, 16'h0020);
        drive_ord(7, 16'h0020);
        ord_valid = 1'b0;
        wait_idle();
        check("overflow_word", mem[7], 32'hFFFF_FFF0);

        w0 = we_cycles;
        push_ord(9, 16'h0000);
        drive_ord(9, 16'h0000);
        ord_valid = 1'b0;
        wait_idle();
        check("maxzero_q0_word", mem[9], 32'h0000_0000);
        check("maxzero_q0_we", 32'(we_cycles - w0), 32'(WR_WAIT));
        push_ord(9, 16'h0001);
        drive_ord(9, 16'h0001);
        ord_valid = 1'b0;
        wait_idle();
        check("maxzero_q1_word", mem[9], 32'h0000_0000);

        // Order that would be accepted, killed by reset in its 3rd write cycle.
        drive_ord(12, 16'h0005);
        ord_valid = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!mem_we && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("midwr_we_seen", 32'(mem_we), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midwr_we_cleared", 32'(mem_we),     32'd0);
        check("midwr_busy",       32'(busy),       32'd0);
        check("midwr_no_resp",    32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midwr_we_stays_low", 32'(mem_we), 32'd0);

        // Both requesters rise together right out of reset, two requests each.
        @(negedge clk);
        grant_log.delete();
        push_ord(10, 16'h0001);
        push_cfg(20, 16'h0777);
        push_ord(11, 16'h0001);
        push_cfg(21, 16'h0888);
        ord_client = 10;
        ord_qty    = 16'h0001;
        cfg_client = 20;
        cfg_max    = 16'h0777;
        ord_valid  = 1'b1;
        cfg_valid  = 1'b1;
        rst_n      = 1'b1;
        fork
            begin
                drive_ord(10, 16'h0001);
                drive_ord(11, 16'h0001);
                ord_valid = 1'b0;
            end
            begin
                drive_cfg(20, 16'h0777);
                drive_cfg(21, 16'h0888);
                cfg_valid = 1'b0;
            end
            begin
                @(negedge clk);
                check("first_grant_ready", 32'({cfg_ready, ord_ready}), 32'b01);
            end
        join
        wait_idle();
        check("tie_grant_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("tie_grant0", 32'(grant_log[0]), 32'd0);
            check("tie_grant1", 32'(grant_log[1]), 32'd1);
            check("tie_grant2", 32'(grant_log[2]), 32'd0);
            check("tie_grant3", 32'(grant_log[3]), 32'd1);
        end
        check("tie_word10", mem[10], ref_mem[10]);
        check("tie_word11", mem[11], ref_mem[11]);
        check("tie_word20", mem[20], ref_mem[20]);
        check("tie_word21", mem[21], ref_mem[21]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risk_mem_arbiter.md
RISK_MEM_ARBITER -- requirements
Module: risk_mem_arbiter

Interface
REQ-001 SHALL have parameter RD_WAIT, default 4, memory read latency in clk cycles from mem_rdindex stable to mem_rdata valid.
REQ-002 SHALL have parameter WR_WAIT, default 6, cycles mem_we/mem_wdata/mem_rdindex are held stable per write.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports ord_valid input 1, ord_ready output 1, ord_client input 9, ord_qty input 16: order requester, valid/ready handshake.
REQ-006 SHALL have ports cfg_valid input 1, cfg_ready output 1, cfg_client input 9, cfg_max input 16: max-to-trade configuration requester.
REQ-007 SHALL have ports resp_valid output 1, resp_accept output 1, resp_client output 9: one-cycle order verdict pulse.
REQ-008 SHALL have ports mem_rdindex output 9, mem_we output 1, mem_wdata output 32, mem_rdata input 32: client risk-memory port; word = {max[31:16], accumulated[15:0]}.
REQ-009 SHALL have port busy output 1: high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, RD, CHECK, WR, RESP.
REQ-011 IDLE: accepting a request SHALL latch client/operand and the request type, drive mem_rdindex=client, and go to RD.
REQ-012 Handshake: a transfer SHALL occur only in a cycle where valid and ready are both high; ready SHALL be high only in IDLE, and only for the granted requester.
REQ-013 Arbitration: single pending requester SHALL be granted. When both are pending, the grant SHALL go to the one not granted last (round-robin). The last-grant pointer SHALL reset to cfg, so the order port wins the first tie.
REQ-014 RD: SHALL count RD_WAIT cycles with mem_rdindex held, then capture mem_rdata into a 32-bit register and go to CHECK.
REQ-015 CHECK (order): sum = acc + ord_qty, computed 17 bits wide. Accept iff sum[16]==0 and sum[15:0] <= max.
REQ-016 CHECK (order): on accept, SHALL go to WR with wdata={max, sum[15:0]}. On reject, SHALL go directly to RESP with no write.
REQ-017 CHECK (cfg): SHALL go to WR with wdata={cfg_max, acc}; the accumulated field SHALL be preserved.
REQ-018 WR: SHALL assert mem_we with mem_wdata and mem_rdindex stable for exactly WR_WAIT cycles. Then cfg SHALL go to IDLE, order to RESP.
REQ-019 RESP: resp_valid SHALL be high for one cycle with resp_accept and resp_client; next state IDLE.
REQ-020 Latency, order accept: grant to resp_valid SHALL be RD_WAIT+WR_WAIT+2 cycles.
REQ-021 Latency, order reject: grant to resp_valid SHALL be RD_WAIT+2 cycles.
REQ-022 Exactly one operation SHALL be outstanding; requests arriving while busy SHALL wait (ready low) and SHALL NOT be dropped.
REQ-023 mem_we SHALL be low in every state except WR.
REQ-024 Max value 0 SHALL reject any order with qty>0. A qty=0 order SHALL be accepted and rewrite the same value.
REQ-025 Outputs ord_ready, cfg_ready and resp_* SHALL be registered; mem_rdindex SHALL be held from grant until the end of WR/RESP.

Reset
REQ-026 While rst_n==0 at posedge clk: state=IDLE, counters=0, mem_we=0, mem_wdata=0, mem_rdindex=0, resp_valid=0, resp_accept=0, resp_client=0, ord_ready=0, cfg_ready=0, busy=0, pointer=cfg.
REQ-027 Reset during RD/WR SHALL abort the operation: no further write, no response. The first grant SHALL be possible in the 2nd cycle after rst_n rises.

Verification
REQ-028 Config then order: cfg client 5 max 0x0100 (acc 0x0010) -> word 0x01000010. Then order client 5 qty 0x00F0 -> accept, word 0x01000100, resp at +12 cycles.
REQ-029 Over-limit: word 0x01000100, order qty 1 -> resp_accept=0, mem_we never high, resp at +6 cycles.
REQ-030 Overflow: word 0xFFFFFFF0, order qty 0x0020 -> reject (sum[16]=1), word unchanged.
REQ-031 Tie: ord_valid and cfg_valid rise together, each held valid with 2 requests -> grants order, cfg, order, cfg; none lost.
REQ-032 Reset mid-WR: rst_n low in 3rd WR cycle -> mem_we=0 next edge, no resp_valid, busy=0.
REQ-033 Max zero: max 0x0000, order qty 0 -> accept; order qty 1 -> reject.
